// File: rtl/imm_extend_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_extend_pipe: immediate extender feeding a 2-entry ready/valid FIFO.   |
// | Option macro: IMMEXT_LUI_EN (Mode 10 = load-upper). Rev 1.0               |
// +--------------------------------------------------------------------------+
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  In,
   input  logic [1:0]       Mode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] Out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       Count
);

   localparam int c_PAD_W = OUT_W - IN_W;

   generate
      if (OUT_W < IN_W + 2) begin : g_bad_width
         $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
      end
   endgenerate

   logic [OUT_W-1:0] w_zext;
   logic [OUT_W-1:0] w_sext;
   logic [OUT_W-1:0] w_ext;
   logic             w_push;
   logic             w_pop;

   logic [OUT_W-1:0] r_mem [2];
   logic             r_head;
   logic             r_tail;
   logic [1:0]       r_count;

   assign w_zext = {{c_PAD_W{1'b0}}, In};
   assign w_sext = {{c_PAD_W{In[IN_W-1]}}, In};

   always_comb begin
      w_ext = w_zext;
      case (Mode)
         2'b00: w_ext = w_zext;
         2'b01: w_ext = w_sext;
`ifdef IMMEXT_LUI_EN
         2'b10: w_ext = {In, {c_PAD_W{1'b0}}};
`else
         2'b10: w_ext = w_zext;
`endif
         2'b11: w_ext = {w_sext[OUT_W-3:0], 2'b00};
         default: w_ext = w_zext;
      endcase
   end

   // Handshake flags come from registered occupancy only, never from inputs.
   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign Count     = r_count;
   assign Out       = out_valid ? r_mem[r_head] : '0;

   assign w_push = in_valid & in_ready;
   assign w_pop  = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_head   <= 1'b0;
         r_tail   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= w_ext;
            r_tail        <= ~r_tail;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imm_extend_pipe: randomized + directed check against a queue model.   |
// | Honours IMMEXT_LUI_EN the same way as the design. Rev 1.0                 |
// +--------------------------------------------------------------------------+
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] In = '0;
   logic [1:0]  Mode = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] Out;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [1:0]  Count;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] q[$];

   imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
      .clk(clk), .rst(rst), .In(In), .Mode(Mode), .in_valid(in_valid),
      .in_ready(in_ready), .Out(Out), .out_valid(out_valid),
      .out_ready(out_ready), .Count(Count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ext(input logic [15:0] v, input logic [1:0] m);
      int s;
      s = int'($signed(v));
      case (m)
         2'd0: return {16'h0000, v};
         2'd1: return s;
`ifdef IMMEXT_LUI_EN
         2'd2: return {v, 16'h0000};
`else
         2'd2: return {16'h0000, v};
`endif
         default: return s * 4;
      endcase
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference FIFO: acceptance decided from occupancy before the edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
      end else begin
         case (q.size())
            0: if (in_valid) q.push_back(ext(In, Mode));
            1: begin
               if (out_ready) void'(q.pop_front());
               if (in_valid) q.push_back(ext(In, Mode));
            end
            default: if (out_ready) void'(q.pop_front());
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("model_count", {62'd0, Count}, 64'(q.size()));
         check("model_out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
         check("model_in_ready", {63'd0, in_ready}, {63'd0, q.size() != 2});
         check("model_out", {32'd0, Out}, {32'd0, (q.size() != 0) ? q[0] : 32'd0});
      end
   end

   task automatic lit(input logic [15:0] v, input logic [1:0] m, input logic [31:0] exp,
                      input string nm);
      In = v; Mode = m; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check(nm, {32'd0, Out}, {32'd0, exp});
      check({nm, "_count"}, {62'd0, Count}, 64'd1);
      check({nm, "_valid"}, {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [31:0] exp_o;

      repeat (2) @(posedge clk);
      #2;
      check("reset_count", {62'd0, Count}, 64'd0);
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);
      check("reset_out", {32'd0, Out}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      lit(16'h8001, 2'b00, 32'h00008001, "zero_fill");
      lit(16'h8001, 2'b01, 32'hFFFF8001, "sign_ext");
      lit(16'hFFFF, 2'b11, 32'hFFFFFFFC, "branch_neg");
      lit(16'h4001, 2'b11, 32'h00010004, "branch_pos");
`ifdef IMMEXT_LUI_EN
      lit(16'h1234, 2'b10, 32'h12340000, "load_upper");
`else
      lit(16'h1234, 2'b10, 32'h00001234, "mode10_zero_fill");
`endif

      // Fill with the consumer stalled, then try a refused third push.
      exp_a = 32'hFFFFA5A5; exp_b = 32'h00000C3C;
      out_ready = 1'b0; in_valid = 1'b1; In = 16'hA5A5; Mode = 2'b01;
      @(posedge clk); #1;
      In = 16'h0C3C; Mode = 2'b00;
      @(posedge clk); #1;
      In = 16'h7777; Mode = 2'b00;
      @(negedge clk);
      check("full_count", {62'd0, Count}, 64'd2);
      check("full_in_ready", {63'd0, in_ready}, 64'd0);
      check("full_head", {32'd0, Out}, {32'd0, exp_a});
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("refused_count", {62'd0, Count}, 64'd2);
      check("stall_head", {32'd0, Out}, {32'd0, exp_a});
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("drain_b", {32'd0, Out}, {32'd0, exp_b});
      check("drain_b_count", {62'd0, Count}, 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("drained_count", {62'd0, Count}, 64'd0);

      // Streaming at occupancy 1: each edge pops the old item and pushes a new one.
      out_ready = 1'b0; in_valid = 1'b1; In = 16'h0001; Mode = 2'b00;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         In = 16'($urandom); Mode = 2'($urandom_range(0, 3));
         exp_o = ext(In, Mode);
         @(posedge clk); #1;
         @(negedge clk);
         check("stream_count", {62'd0, Count}, 64'd1);
         check("stream_out", {32'd0, Out}, {32'd0, exp_o});
      end
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Fill, then pulse reset between clock edges.
      out_ready = 1'b0; in_valid = 1'b1; In = 16'h1111;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_valid", {63'd0, out_valid}, 64'd0);
      check("async_rst_count", {62'd0, Count}, 64'd0);
      check("async_rst_out", {32'd0, Out}, 64'd0);
      rst = 1'b0;
      #1;
      check("rst_release_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            #1;
            rst = 1'b0;
         end
         In = 16'($urandom);
         Mode = 2'($urandom_range(0, 3));
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         @(posedge clk); #1;
      end

      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
